bus_xbar_n: RTL and testbench
=============================

// Module: bus_xbar_n
// PURPOSE
//  Parametrised single-master Wishbone-style interconnect, successor to the fixed 8-slave bus glue.
//  Decodes the master address into one of NUM_SLAVES slave ports and registers the transaction.
//  Adds a strobe handshake, a per-transaction watchdog and a bus-error response.
//  Sits between the CPU memory stage and the RAM/ROM/flash/UART/digseg peripheral controllers.
// PARAMETERS
//  NUM_SLAVES  8     number of slave ports, 1..16
//  ADDR_W      32    address width
//  DATA_W      32    data width
//  SEL_W       4     byte-select width (DATA_W/8)
//  DEC_HI      31    MSB of the slave-index field in the address
//  DEC_LO      28    LSB of the slave-index field; the field holds DEC_HI-DEC_LO+1 bits
//  TIMEOUT     255   cycles BUSY waits for a slave ack before reporting an error, 1..65535
// PORTS
//  clk             in   1                 system clock
//  rst             in   1                 synchronous reset, active-high
//  m_stb_i         in   1                 master request strobe; held until m_ack_o
//  m_addr_i        in   ADDR_W            master address
//  m_data_i        in   DATA_W            master write data
//  m_we_i          in   1                 1 = write, 0 = read
//  m_select_i      in   SEL_W             byte lanes
//  m_data_o        out  DATA_W            read data, valid while m_ack_o = 1
//  m_ack_o         out  1                 one-cycle completion pulse
//  m_err_o         out  1                 with m_ack_o: transaction failed (unmapped or timeout)
//  s_stb_o         out  NUM_SLAVES        one-hot slave strobe
//  s_addr_o        out  ADDR_W            latched address, shared by all slaves
//  s_data_o        out  DATA_W            latched write data, shared
//  s_we_o          out  1                 latched write enable, shared
//  s_select_o      out  SEL_W             latched byte lanes, shared
//  s_data_i        in   NUM_SLAVES*DATA_W slave read data, slave k at [k*DATA_W +: DATA_W]
//  s_ack_i         in   NUM_SLAVES        slave acks
//  err_count_o     out  16                saturating count of error responses
//  err_addr_o      out  ADDR_W            address of the most recent errored transaction
// BEHAVIOUR
//  - Reset: state IDLE; every output 0, including s_stb_o, counters and latched fields.
//  - States: IDLE, BUSY, RESP.
//  - IDLE: when m_stb_i = 1, latch addr/data/we/select and idx = m_addr_i[DEC_HI:DEC_LO].
//      idx <  NUM_SLAVES: go to BUSY, set s_stb_o[idx].
//      idx >= NUM_SLAVES: go to RESP with err = 1; no slave is strobed.
//  - BUSY: hold s_stb_o[idx] and the latched fields stable; watchdog counts from 0.
//      If s_ack_i[idx] = 1: capture s_data_i slice idx, drop s_stb_o, go to RESP with err = 0.
//      Else if count reaches TIMEOUT-1: drop s_stb_o, go to RESP with err = 1.
//      Ack wins when ack and timeout occur in the same cycle.
//      Acks from non-selected slaves are ignored.
//  - RESP: one cycle with m_ack_o = 1 and m_err_o = err.
//      m_data_o = captured data for a successful read, 0 for a write or an error.
//      On error: err_count_o += 1 (saturating at 0xFFFF), err_addr_o = latched address.
//      m_stb_i is ignored in this cycle; next state is IDLE unconditionally.
//  - Outside RESP, m_ack_o, m_err_o and m_data_o are 0.
//  - Latency: master strobe at cycle 0 -> slave strobe at cycle 1.
//      Slave ack at cycle k -> m_ack_o at cycle k+1.
//      Unmapped address -> m_ack_o at cycle 1.
//  - The master must deassert m_stb_i in the cycle after m_ack_o; IDLE samples a fresh request.
//  - Reset mid-transaction aborts immediately: s_stb_o = 0 and no ack or error is reported.
// STRUCTURE
//  - defines.v gains the state encodings (BUS_IDLE/BUS_BUSY/BUS_RESP) and `BusErrCntBus [15:0].
//  - Existing `WB_AddrBus/`WB_DataBus/`WB_SelectBus macros are reused for the default widths.
//  - Sub-module bus_watchdog: clear/enable inputs, TIMEOUT parameter, expired output pulse.
//  - Decode, the slave-data mux and the FSM live in this module.
// TESTING
//  1. Read 0x1000_0010, slave1 acks 3 cycles after its strobe with 0xCAFE_F00D
//     -> m_ack_o=1, m_err_o=0, m_data_o=0xCAFE_F00D exactly 1 cycle after s_ack_i[1].
//  2. Write 0x6000_0004, data 0x0000_00A5, select 4'b0001
//     -> s_stb_o=8'h40, s_we_o=1, s_data_o=0xA5, s_select_o=1; m_data_o=0 on ack.
//  3. NUM_SLAVES=6, access 0x7000_0000
//     -> m_ack_o and m_err_o at cycle 1, s_stb_o stays 0, err_count_o=1, err_addr_o=0x7000_0000.
//  4. TIMEOUT=16, slave2 never acks
//     -> error response 16 cycles after s_stb_o rises; s_stb_o deasserts the same cycle RESP begins.
//  5. Slave3 acks while slave2 is selected, then slave2 acks on the timeout cycle
//     -> stray ack ignored; success with slave2 data.
//  6. Assert rst during BUSY
//     -> next cycle all outputs 0, no m_ack_o; a following access completes normally.

Source files
------------

// File: rtl/bus_xbar_n_pkg.sv
// Shared types, default widths and helpers for the bus_xbar_n single-master interconnect.
package bus_xbar_n_pkg;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 4;
  localparam int ERR_CNT_W = 16;

  typedef enum logic [1:0] {
    BUS_IDLE = 2'd0,
    BUS_BUSY = 2'd1,
    BUS_RESP = 2'd2
  } bus_state_e;

  typedef logic [ERR_CNT_W-1:0] err_cnt_t;

  function automatic err_cnt_t err_cnt_inc(input err_cnt_t cnt);
    if (cnt == {ERR_CNT_W{1'b1}}) begin
      return cnt;
    end else begin
      return cnt + 16'd1;
    end
  endfunction

endpackage

// File: rtl/bus_xbar_n_if.sv
// Master-side and slave-side bus signals of bus_xbar_n; the slave modport is the interconnect's view,
// the master modport is the view of the surrounding CPU and peripheral controllers.
interface bus_xbar_n_if
  import bus_xbar_n_pkg::*;
#(
  parameter int NUM_SLAVES = 8,
  parameter int ADDR_W     = WB_ADDR_W,
  parameter int DATA_W     = WB_DATA_W,
  parameter int SEL_W      = WB_SEL_W
);
  logic                         m_stb_i;
  logic [ADDR_W-1:0]            m_addr_i;
  logic [DATA_W-1:0]            m_data_i;
  logic                         m_we_i;
  logic [SEL_W-1:0]             m_select_i;
  logic [DATA_W-1:0]            m_data_o;
  logic                         m_ack_o;
  logic                         m_err_o;
  logic [NUM_SLAVES-1:0]        s_stb_o;
  logic [ADDR_W-1:0]            s_addr_o;
  logic [DATA_W-1:0]            s_data_o;
  logic                         s_we_o;
  logic [SEL_W-1:0]             s_select_o;
  logic [NUM_SLAVES*DATA_W-1:0] s_data_i;
  logic [NUM_SLAVES-1:0]        s_ack_i;

  modport slave (
    input  m_stb_i, m_addr_i, m_data_i, m_we_i, m_select_i, s_data_i, s_ack_i,
    output m_data_o, m_ack_o, m_err_o, s_stb_o, s_addr_o, s_data_o, s_we_o, s_select_o
  );

  modport master (
    output m_stb_i, m_addr_i, m_data_i, m_we_i, m_select_i, s_data_i, s_ack_i,
    input  m_data_o, m_ack_o, m_err_o, s_stb_o, s_addr_o, s_data_o, s_we_o, s_select_o
  );

endinterface

// File: rtl/bus_xbar_n_watchdog.sv
// Per-transaction watchdog: counts enabled cycles from zero and flags the cycle the count hits TIMEOUT-1.
module bus_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

  logic [15:0] count_r;

  assign expired = enable & (count_r == LAST);

  // Cycle counter, held at its last value once expired until cleared
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= 16'd0;
    end else if (clear) begin
      count_r <= 16'd0;
    end else if (enable && !expired) begin
      count_r <= count_r + 16'd1;
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/bus_xbar_n.sv
// Single-master interconnect: decodes the address onto NUM_SLAVES slave ports, registers the
// transaction, and answers with data, or with an error for unmapped addresses and slave timeouts.
module bus_xbar_n
  import bus_xbar_n_pkg::*;
#(
  parameter int NUM_SLAVES = 8,
  parameter int ADDR_W     = WB_ADDR_W,
  parameter int DATA_W     = WB_DATA_W,
  parameter int SEL_W      = WB_SEL_W,
  parameter int DEC_HI     = 31,
  parameter int DEC_LO     = 28,
  parameter int TIMEOUT    = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  bus_xbar_n_if.slave          bus,
  output logic [ERR_CNT_W-1:0] err_count_o,
  output logic [ADDR_W-1:0]    err_addr_o
);

  localparam int IDX_W = DEC_HI - DEC_LO + 1;

  bus_state_e            state_r, state_next_s;
  logic [NUM_SLAVES-1:0] s_stb_r, stb_next_s, onehot_s;
  logic [ADDR_W-1:0]     s_addr_r, err_addr_r;
  logic [DATA_W-1:0]     s_data_r, m_data_r, mux_data_s;
  logic [SEL_W-1:0]      s_select_r;
  logic                  s_we_r, m_ack_r, m_err_r;
  err_cnt_t              err_count_r;
  logic [31:0]           idx_s;
  logic                  mapped_s, ack_hit_s, wd_expired_s;
  logic                  latch_s, enter_resp_s, err_next_s;

  // Zero-extended slave index and its one-hot strobe pattern
  always_comb begin
    idx_s = 32'd0;
    idx_s[IDX_W-1:0] = bus.m_addr_i[DEC_HI:DEC_LO];
    for (int k = 0; k < NUM_SLAVES; k++) begin
      onehot_s[k] = (idx_s == 32'(k));
    end
  end

  assign mapped_s  = (idx_s < 32'(NUM_SLAVES));
  // Masking with the live strobe makes acks from unselected slaves invisible
  assign ack_hit_s = |(s_stb_r & bus.s_ack_i);

  // Read-data mux steered by the registered one-hot strobe
  always_comb begin
    mux_data_s = {DATA_W{1'b0}};
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (s_stb_r[k]) begin
        mux_data_s = mux_data_s | bus.s_data_i[k*DATA_W +: DATA_W];
      end else begin
        mux_data_s = mux_data_s;
      end
    end
  end

  bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_r != BUS_BUSY),
    .enable  (state_r == BUS_BUSY),
    .expired (wd_expired_s)
  );

  // Next-state and transaction control decode
  always_comb begin
    state_next_s = state_r;
    stb_next_s   = s_stb_r;
    latch_s      = 1'b0;
    enter_resp_s = 1'b0;
    err_next_s   = 1'b0;
    case (state_r)
      BUS_IDLE: begin
        if (bus.m_stb_i) begin
          latch_s      = 1'b1;
          if (mapped_s) begin
            state_next_s = BUS_BUSY;
            stb_next_s   = onehot_s;
          end else begin
            state_next_s = BUS_RESP;
            enter_resp_s = 1'b1;
            err_next_s   = 1'b1;
          end
        end else begin
          state_next_s = BUS_IDLE;
        end
      end
      BUS_BUSY: begin
        if (ack_hit_s) begin
          state_next_s = BUS_RESP;
          stb_next_s   = {NUM_SLAVES{1'b0}};
          enter_resp_s = 1'b1;
        end else if (wd_expired_s) begin
          state_next_s = BUS_RESP;
          stb_next_s   = {NUM_SLAVES{1'b0}};
          enter_resp_s = 1'b1;
          err_next_s   = 1'b1;
        end else begin
          state_next_s = BUS_BUSY;
        end
      end
      BUS_RESP: begin
        state_next_s = BUS_IDLE;
      end
      default: begin
        state_next_s = BUS_IDLE;
        stb_next_s   = {NUM_SLAVES{1'b0}};
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= BUS_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Latched request, response and error-log registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s_stb_r     <= {NUM_SLAVES{1'b0}};
      s_addr_r    <= {ADDR_W{1'b0}};
      s_data_r    <= {DATA_W{1'b0}};
      s_we_r      <= 1'b0;
      s_select_r  <= {SEL_W{1'b0}};
      m_ack_r     <= 1'b0;
      m_err_r     <= 1'b0;
      m_data_r    <= {DATA_W{1'b0}};
      err_count_r <= 16'd0;
      err_addr_r  <= {ADDR_W{1'b0}};
    end else begin
      s_stb_r <= stb_next_s;
      if (latch_s) begin
        s_addr_r   <= bus.m_addr_i;
        s_data_r   <= bus.m_data_i;
        s_we_r     <= bus.m_we_i;
        s_select_r <= bus.m_select_i;
      end
      m_ack_r <= enter_resp_s;
      m_err_r <= enter_resp_s & err_next_s;
      if (enter_resp_s && !err_next_s && !s_we_r) begin
        m_data_r <= mux_data_s;
      end else begin
        m_data_r <= {DATA_W{1'b0}};
      end
      // Unmapped errors are logged on the latching edge, so take the address straight from the master
      if (enter_resp_s && err_next_s) begin
        err_count_r <= err_cnt_inc(err_count_r);
        err_addr_r  <= latch_s ? bus.m_addr_i : s_addr_r;
      end
    end
  end

  assign bus.s_stb_o    = s_stb_r;
  assign bus.s_addr_o   = s_addr_r;
  assign bus.s_data_o   = s_data_r;
  assign bus.s_we_o     = s_we_r;
  assign bus.s_select_o = s_select_r;
  assign bus.m_ack_o    = m_ack_r;
  assign bus.m_err_o    = m_err_r;
  assign bus.m_data_o   = m_data_r;
  assign err_count_o    = err_count_r;
  assign err_addr_o     = err_addr_r;

endmodule

// File: tb/tb_bus_xbar_n.sv
// Table-driven scoreboard bench for bus_xbar_n: an 8-slave instance with a short watchdog,
// plus a 6-slave instance for the unmapped-address case.
module tb_bus_xbar_n;
  import bus_xbar_n_pkg::*;

  localparam int TMO      = 16;
  localparam int MAX_WAIT = 40;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  sel;
    int          ack_dly;    // cycles after the strobe is seen; -1 = slave never acks
    logic [31:0] sdata;
    int          stray_slv;  // -1 = no stray ack
    int          stray_cyc;
    logic [7:0]  exp_stb;
    logic        exp_err;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] err_count8, err_count6;
  logic [31:0] err_addr8, err_addr6;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb_q[$];
  vec_t vecs[9];
  int   exp_cnt = 0;
  logic [31:0] exp_eaddr = 32'd0;

  always #5 clk = ~clk;

  bus_xbar_n_if #(.NUM_SLAVES(8)) bus8 ();
  bus_xbar_n_if #(.NUM_SLAVES(6)) bus6 ();

  bus_xbar_n #(.NUM_SLAVES(8), .TIMEOUT(TMO)) u_dut8 (
    .clk(clk), .rst(rst), .bus(bus8), .err_count_o(err_count8), .err_addr_o(err_addr8)
  );

  bus_xbar_n #(.NUM_SLAVES(6), .TIMEOUT(TMO)) u_dut6 (
    .clk(clk), .rst(rst), .bus(bus6), .err_count_o(err_count6), .err_addr_o(err_addr6)
  );

  assign bus6.m_addr_i   = bus8.m_addr_i;
  assign bus6.m_data_i   = bus8.m_data_i;
  assign bus6.m_we_i     = bus8.m_we_i;
  assign bus6.m_select_i = bus8.m_select_i;
  assign bus6.s_data_i   = '0;
  assign bus6.s_ack_i    = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                              input logic [3:0] sel, input int dly, input logic [31:0] sdata,
                              input int st_slv, input int st_cyc, input logic [7:0] stb,
                              input logic err, input logic [31:0] data, input int lat);
    vec_t v;
    v.addr = addr; v.wdata = wdata; v.we = we; v.sel = sel; v.ack_dly = dly; v.sdata = sdata;
    v.stray_slv = st_slv; v.stray_cyc = st_cyc; v.exp_stb = stb; v.exp_err = err;
    v.exp_data = data; v.exp_lat = lat;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int   c;
    bit   seen;
    int   slv;
    exp_t e;
    slv = int'(v.addr[31:28]);
    sb_q.push_back('{err: v.exp_err, data: v.exp_data, lat: v.exp_lat});
    if (v.exp_err) begin
      exp_cnt++;
      exp_eaddr = v.addr;
    end
    bus8.m_addr_i   = v.addr;
    bus8.m_data_i   = v.wdata;
    bus8.m_we_i     = v.we;
    bus8.m_select_i = v.sel;
    bus8.m_stb_i    = 1'b1;
    c = 0;
    seen = 1'b0;
    while (!seen && c < MAX_WAIT) begin
      @(negedge clk);
      c++;
      bus8.s_ack_i = 8'd0;
      if (c == 1) begin
        chk("s_addr", bus8.s_addr_o, v.addr);
        chk("s_wfields", {bus8.s_we_o, bus8.s_select_o, bus8.s_data_o}, {v.we, v.sel, v.wdata});
      end
      if (bus8.m_ack_o) begin
        seen = 1'b1;
        bus8.m_stb_i = 1'b0;
        chk("stb_drop_on_resp", bus8.s_stb_o, 8'd0);
        if (sb_q.size() == 0) begin
          chk("sb_empty", 1'b1, 1'b0);
        end else begin
          e = sb_q.pop_front();
          chk("m_err", bus8.m_err_o, e.err);
          chk("m_data", bus8.m_data_o, e.data);
          chk("ack_latency", c, e.lat);
        end
      end else begin
        chk("s_stb_hold", bus8.s_stb_o, v.exp_stb);
        if (v.ack_dly >= 0 && c == v.ack_dly + 1) begin
          bus8.s_ack_i[slv] = 1'b1;
          bus8.s_data_i[slv*32 +: 32] = v.sdata;
        end
        if (v.stray_slv >= 0 && c == v.stray_cyc) begin
          bus8.s_ack_i[v.stray_slv] = 1'b1;
          bus8.s_data_i[v.stray_slv*32 +: 32] = 32'hBAD0_0000 | 32'(v.stray_slv);
        end
      end
    end
    if (!seen) begin
      chk("ack_wait_timeout", 1'b0, 1'b1);
      bus8.m_stb_i = 1'b0;
      void'(sb_q.pop_front());
    end
    @(negedge clk);
    chk("ack_pulse_end", {bus8.m_ack_o, bus8.m_err_o, bus8.m_data_o}, 34'd0);
    chk("err_count", err_count8, 16'(exp_cnt));
    chk("err_addr", err_addr8, exp_eaddr);
  endtask

  initial begin
    vecs[0] = mk(32'h1000_0010, 32'h0, 1'b0, 4'hF, 3,  32'hCAFE_F00D, -1, 0, 8'h02, 1'b0, 32'hCAFE_F00D, 5);
    vecs[1] = mk(32'h6000_0004, 32'hA5, 1'b1, 4'h1, 1, 32'hDEAD_BEEF, -1, 0, 8'h40, 1'b0, 32'h0, 3);
    vecs[2] = mk(32'h0000_0000, 32'h0, 1'b0, 4'hF, 0,  32'h1234_5678, -1, 0, 8'h01, 1'b0, 32'h1234_5678, 2);
    vecs[3] = mk(32'h7000_0100, 32'h0, 1'b0, 4'h3, 5,  32'h8765_4321, -1, 0, 8'h80, 1'b0, 32'h8765_4321, 7);
    vecs[4] = mk(32'h9000_0000, 32'h11, 1'b0, 4'hF, -1, 32'h0,        -1, 0, 8'h00, 1'b1, 32'h0, 1);
    vecs[5] = mk(32'h2000_0000, 32'h0, 1'b0, 4'hF, -1, 32'h0,         -1, 0, 8'h04, 1'b1, 32'h0, TMO + 1);
    vecs[6] = mk(32'h3000_0000, 32'h0, 1'b0, 4'hF, TMO - 1, 32'h0303_0303, -1, 0, 8'h08, 1'b0, 32'h0303_0303, TMO + 1);
    vecs[7] = mk(32'h2000_0040, 32'h0, 1'b0, 4'hF, TMO - 1, 32'h5A5A_0002, 3, 3, 8'h04, 1'b0, 32'h5A5A_0002, TMO + 1);
    vecs[8] = mk(32'h4000_0008, 32'h0F0F_1234, 1'b1, 4'hF, 2, 32'h4444_4444, -1, 0, 8'h10, 1'b0, 32'h0, 4);

    bus8.m_stb_i = 1'b0; bus8.m_addr_i = 32'd0; bus8.m_data_i = 32'd0;
    bus8.m_we_i = 1'b0; bus8.m_select_i = 4'd0;
    bus8.s_data_i = '0; bus8.s_ack_i = 8'd0;
    bus6.m_stb_i = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_master", {bus8.m_ack_o, bus8.m_err_o, bus8.m_data_o}, 34'd0);
    chk("reset_slave", {bus8.s_stb_o, bus8.s_addr_o, bus8.s_data_o, bus8.s_we_o, bus8.s_select_o}, 64'd0);
    chk("reset_errlog", {err_count8, err_addr8}, 48'd0);

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i]);
    end

    // Unmapped address on the 6-slave instance: immediate error, no slave strobe
    bus8.m_addr_i = 32'h7000_0000;
    bus6.m_stb_i  = 1'b1;
    @(negedge clk);
    bus6.m_stb_i = 1'b0;
    chk("n6_ack_err", {bus6.m_ack_o, bus6.m_err_o}, 2'b11);
    chk("n6_data", bus6.m_data_o, 32'd0);
    chk("n6_stb", bus6.s_stb_o, 6'd0);
    chk("n6_err_count", err_count6, 16'd1);
    chk("n6_err_addr", err_addr6, 32'h7000_0000);
    @(negedge clk);
    chk("n6_ack_end", bus6.m_ack_o, 1'b0);

    // Reset while BUSY aborts silently; the next access completes normally
    bus8.m_addr_i = 32'h1000_0000; bus8.m_we_i = 1'b0; bus8.m_stb_i = 1'b1;
    @(negedge clk);
    chk("pre_rst_stb", bus8.s_stb_o, 8'h02);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_busy_master", {bus8.m_ack_o, bus8.m_err_o, bus8.m_data_o}, 34'd0);
    chk("rst_busy_slave", {bus8.s_stb_o, bus8.s_addr_o}, 40'd0);
    chk("rst_busy_errlog", err_count8, 16'd0);
    rst = 1'b0;
    bus8.m_stb_i = 1'b0;
    exp_cnt = 0;
    exp_eaddr = 32'd0;
    @(negedge clk);
    chk("post_rst_idle", {bus8.m_ack_o, bus8.s_stb_o}, 9'd0);
    run_vec(vecs[0]);

    chk("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
